// File: rtl/ptw_req_arbiter.sv
// ptw_req_arbiter
//   Shares one page-table walker between two translation requesters
//   (0 = Dcache, 1 = Icache). One walk is outstanding at a time. The FSM
//   cycles IDLE -> ISSUE -> WAIT -> IDLE. Grants are round-robin.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   reqN_valid/ready/vpn      translation request handshake per requester
//   respN_valid               one-cycle response strobe to the owning requester
//   resp_ae, resp_pte         access-exception flag and PTE of the routed response
//   ptw_req_valid/ready/vpn   request channel to the walker
//   ptw_resp_valid/ae/pte     response channel from the walker
//   busy, owner               status: not IDLE / requester holding the walker
//   err_spurious, err_timeout sticky error flags
module ptw_req_arbiter #(
  parameter int VPN_W   = 27,
  parameter int PTE_W   = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [VPN_W-1:0] req0_vpn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [VPN_W-1:0] req1_vpn,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic             resp_ae,
  output logic [PTE_W-1:0] resp_pte,
  output logic             ptw_req_valid,
  input  logic             ptw_req_ready,
  output logic [VPN_W-1:0] ptw_req_vpn,
  input  logic             ptw_resp_valid,
  input  logic             ptw_resp_ae,
  input  logic [PTE_W-1:0] ptw_resp_pte,
  output logic             busy,
  output logic             owner,
  output logic             err_spurious,
  output logic             err_timeout
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             last_grant;
  logic             grant_any;
  logic             grant_idx;

  // Round-robin pick in IDLE; on a tie the requester not granted last wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_idx = ~last_grant;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_idx = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_idx = 1'b1;
      end else begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
      end
    end else begin
      grant_any = 1'b0;
      grant_idx = 1'b0;
    end
  end

  assign req0_ready = grant_any & ~grant_idx;
  assign req1_ready = grant_any & grant_idx;

  // Arbiter FSM with registered walker request, response routing and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      busy          <= 1'b0;
      ptw_req_valid <= 1'b0;
      ptw_req_vpn   <= '0;
      resp0_valid   <= 1'b0;
      resp1_valid   <= 1'b0;
      resp_ae       <= 1'b0;
      resp_pte      <= '0;
      err_spurious  <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ptw_resp_valid) begin
            err_spurious <= 1'b1;
          end
          if (grant_any) begin
            ptw_req_vpn   <= grant_idx ? req1_vpn : req0_vpn;
            owner         <= grant_idx;
            ptw_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (ptw_resp_valid) begin
            err_spurious <= 1'b1;
          end
          if (ptw_req_ready) begin
            ptw_req_valid <= 1'b0;
            wait_cnt      <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // A real response beats a timeout landing in the same cycle.
          if (ptw_resp_valid || wait_cnt == CNT_LAST) begin
            resp0_valid <= ~owner;
            resp1_valid <= owner;
            last_grant  <= owner;
            busy        <= 1'b0;
            state       <= IDLE;
            if (ptw_resp_valid) begin
              resp_ae  <= ptw_resp_ae;
              resp_pte <= ptw_resp_pte;
            end else begin
              resp_ae     <= 1'b1;
              resp_pte    <= '0;
              err_timeout <= 1'b1;
            end
          end else if (wait_cnt != CNT_LAST) begin
            wait_cnt <= wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            wait_cnt <= wait_cnt;
          end
        end
        default: begin
          ptw_req_valid <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Bench for ptw_req_arbiter: directed scenarios driven on the falling edge,
// a transaction-level model compared against every output each cycle, and
// hand-computed literal expectations for each scenario.
module tb_ptw_req_arbiter;
  localparam int VPN_W = 27;
  localparam int PTE_W = 64;
  localparam int TO    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [VPN_W-1:0] req0_vpn = '0, req1_vpn = '0;
  logic             resp0_valid, resp1_valid, resp_ae;
  logic [PTE_W-1:0] resp_pte;
  logic             ptw_req_valid;
  logic             ptw_req_ready = 1'b0;
  logic [VPN_W-1:0] ptw_req_vpn;
  logic             ptw_resp_valid = 1'b0;
  logic             ptw_resp_ae = 1'b0;
  logic [PTE_W-1:0] ptw_resp_pte = '0;
  logic             busy, owner, err_spurious, err_timeout;

  ptw_req_arbiter #(.VPN_W(VPN_W), .PTE_W(PTE_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_vpn(req0_vpn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_vpn(req1_vpn),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_ae(resp_ae), .resp_pte(resp_pte),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ae(ptw_resp_ae), .ptw_resp_pte(ptw_resp_pte),
    .busy(busy), .owner(owner), .err_spurious(err_spurious), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Walker model: optional accept stall, response after wk_lat cycles (0 = never).
  bit               wk_en = 1'b1;
  bit               force_resp = 1'b0;
  int               wk_lat = 3, wk_stall = 0, wk_timer = 0, wk_stall_cnt = 0;
  logic [VPN_W-1:0] wk_vpn = '0;

  always @(negedge clk) begin
    #1;
    ptw_req_ready  = wk_en && ptw_req_valid && (wk_stall_cnt >= wk_stall);
    ptw_resp_valid = force_resp || (wk_timer == 1);
    ptw_resp_ae    = wk_vpn[12];
    ptw_resp_pte   = 64'(wk_vpn) * 64'd9 + 64'd5;
    #2;
    if (ptw_req_valid && ptw_req_ready) begin
      wk_vpn       = ptw_req_vpn;
      wk_timer     = wk_lat;
      wk_stall_cnt = 0;
    end else begin
      if (wk_timer > 0) wk_timer--;
      if (ptw_req_valid) wk_stall_cnt++;
      else wk_stall_cnt = 0;
    end
  end

  // Reference model state (transaction view: who holds the walker and how long it has waited).
  int               m_hold = -1;
  bit               m_acc = 1'b0;
  int               m_wait = 0;
  int               m_last = 1;
  int               m_own = 0;
  logic [VPN_W-1:0] m_vpn = '0;
  int               m_strobe = -1;
  logic             m_ae = 1'b0;
  logic [63:0]      m_pte = '0;
  logic             m_es = 1'b0, m_et = 1'b0;

  // Event logs used by the literal checks.
  int          cyc = 0;
  int          glog[$];
  logic [63:0] vpn_log[$];
  int          acc_cyc = 0, acc_cnt = 0, stall_seen = 0;
  int          strobe_cnt = 0, strobe_cyc = 0, resp0_cnt = 0, resp1_cnt = 0;
  logic [63:0] p_pte[2];
  logic        p_ae[2];
  bit          b2b = 1'b0, hs0 = 1'b0, hs1 = 1'b0;
  bit          auto0 = 1'b0, auto1 = 1'b0;

  // Compare process: outputs vs model every cycle, then advance the model.
  always @(negedge clk) begin
    int win;
    #3;
    cyc++;
    win = -1;
    if (!rst && m_hold < 0) begin
      if (req0_valid && req1_valid) win = (m_last == 1) ? 0 : 1;
      else if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
    end
    chk("req0_ready", req0_ready, win == 0);
    chk("req1_ready", req1_ready, win == 1);
    chk("busy", busy, m_hold >= 0);
    chk("ptw_req_valid", ptw_req_valid, (m_hold >= 0) && !m_acc);
    chk("ptw_req_vpn", ptw_req_vpn, m_vpn);
    chk("owner", owner, m_own);
    chk("resp0_valid", resp0_valid, m_strobe == 0);
    chk("resp1_valid", resp1_valid, m_strobe == 1);
    chk("resp_ae", resp_ae, m_ae);
    chk("resp_pte", resp_pte, m_pte);
    chk("err_spurious", err_spurious, m_es);
    chk("err_timeout", err_timeout, m_et);

    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (hs0) glog.push_back(0);
    if (hs1) glog.push_back(1);
    if ((hs0 || hs1) && (resp0_valid || resp1_valid)) b2b = 1'b1;
    if (ptw_req_valid && ptw_req_ready) begin
      acc_cyc = cyc;
      acc_cnt++;
      vpn_log.push_back(64'(ptw_req_vpn));
    end
    if (ptw_req_valid && !ptw_req_ready) stall_seen++;
    if (resp0_valid || resp1_valid) begin
      strobe_cnt++;
      strobe_cyc = cyc;
      if (resp0_valid) begin resp0_cnt++; p_pte[0] = resp_pte; p_ae[0] = resp_ae; end
      if (resp1_valid) begin resp1_cnt++; p_pte[1] = resp_pte; p_ae[1] = resp_ae; end
    end

    if (rst) begin
      m_hold = -1; m_acc = 1'b0; m_wait = 0; m_last = 1; m_own = 0; m_vpn = '0;
      m_strobe = -1; m_ae = 1'b0; m_pte = '0; m_es = 1'b0; m_et = 1'b0;
    end else begin
      m_strobe = -1;
      if (m_hold < 0) begin
        if (ptw_resp_valid) m_es = 1'b1;
        if (win >= 0) begin
          m_hold = win; m_own = win; m_acc = 1'b0;
          m_vpn = (win == 1) ? req1_vpn : req0_vpn;
        end
      end else if (!m_acc) begin
        if (ptw_resp_valid) m_es = 1'b1;
        if (ptw_req_ready) begin m_acc = 1'b1; m_wait = 0; end
      end else if (ptw_resp_valid) begin
        m_strobe = m_hold; m_ae = ptw_resp_ae; m_pte = ptw_resp_pte;
        m_last = m_hold; m_hold = -1;
      end else if (m_wait == TO - 1) begin
        m_strobe = m_hold; m_ae = 1'b1; m_pte = '0; m_et = 1'b1;
        m_last = m_hold; m_hold = -1;
      end else begin
        m_wait++;
      end
    end
  end

  // Advance to the next falling edge; requesters drop valid after a handshake unless re-requesting.
  task automatic tick();
    @(negedge clk);
    if (hs0) req0_valid = auto0;
    if (hs1) req1_valid = auto1;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string nm);
    int  start;
    bit  done;
    start = strobe_cnt;
    done  = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      #4;
      if (strobe_cnt - start >= n) done = 1'b1;
    end
    chk(nm, done, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      #4;
      if (!busy) done = 1'b1;
    end
    chk(nm, done, 1'b1);
  endtask

  initial begin
    int s0, a0;
    // Reset with both requesters already valid: no ready may show during reset.
    req0_vpn = 27'h1000; req1_vpn = 27'h2000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) tick();
    #4;
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ptw_req_vpn", ptw_req_vpn, 64'h0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_errs", {err_spurious, err_timeout}, 2'b00);

    // Tie after reset: requester 0 first, then requester 1.
    tick(); rst = 1'b0; glog.delete(); vpn_log.delete(); b2b = 1'b0;
    wait_strobes(2, 60, "t1_done");
    chk("t1_grant_cnt", glog.size(), 2);
    chk("t1_grant0", glog[0], 0);
    chk("t1_grant1", glog[1], 1);
    chk("t1_vpn0", vpn_log[0], 64'h1000);
    chk("t1_resp0_cnt", resp0_cnt, 1);
    chk("t1_resp1_cnt", resp1_cnt, 1);
    chk("t1_ae0", p_ae[0], 1'b1);
    chk("t1_pte0", p_pte[0], 64'h9005);
    chk("t1_ae1", p_ae[1], 1'b0);
    chk("t1_pte1", p_pte[1], 64'h12005);
    chk("t1_b2b", b2b, 1'b1);

    // Both requesters keep asking: grants alternate.
    tick(); glog.delete(); b2b = 1'b0;
    auto0 = 1'b1; auto1 = 1'b1;
    req0_vpn = 27'h111; req1_vpn = 27'h222; req0_valid = 1'b1; req1_valid = 1'b1;
    wait_strobes(4, 80, "t2_done");
    tick(); auto0 = 1'b0; auto1 = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(40, "t2_idle");
    chk("t2_g0", glog[0], 0);
    chk("t2_g1", glog[1], 1);
    chk("t2_g2", glog[2], 0);
    chk("t2_g3", glog[3], 1);
    chk("t2_b2b", b2b, 1'b1);

    // Walker stalls acceptance 5 cycles per request; last winner was 0 so 1 goes first.
    tick(); wk_stall = 5; stall_seen = 0; glog.delete(); vpn_log.delete();
    req0_vpn = 27'h3abc; req1_vpn = 27'h7777; req0_valid = 1'b1; req1_valid = 1'b1;
    wait_strobes(2, 80, "t3_done");
    chk("t3_stall_cycles", stall_seen, 10);
    chk("t3_g0", glog[0], 1);
    chk("t3_g1", glog[1], 0);
    chk("t3_vpn0", vpn_log[0], 64'h7777);
    chk("t3_vpn1", vpn_log[1], 64'h3abc);
    tick(); wk_stall = 0;

    // Walker silent: timeout response eight cycles after entering WAIT.
    tick(); wk_lat = 0; req1_vpn = 27'h4444; req1_valid = 1'b1;
    wait_strobes(1, 40, "t4_done");
    chk("t4_latency", strobe_cyc - acc_cyc, 9);
    chk("t4_resp1_valid", resp1_valid, 1'b1);
    chk("t4_resp_ae", resp_ae, 1'b1);
    chk("t4_resp_pte", resp_pte, 64'h0);
    chk("t4_err_timeout", err_timeout, 1'b1);
    chk("t4_busy", busy, 1'b0);

    // Walker response while IDLE is spurious.
    tick(); wk_lat = 3; s0 = strobe_cnt; force_resp = 1'b1;
    tick(); force_resp = 1'b0;
    #4;
    chk("t5_err_spurious", err_spurious, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_no_strobe", strobe_cnt, s0);

    // Reset during WAIT, late walker response afterwards.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; wk_lat = 6; a0 = acc_cnt; req0_vpn = 27'h5555; req0_valid = 1'b1;
    for (int i = 0; i < 20 && acc_cnt == a0; i++) begin tick(); #4; end
    chk("t6_accepted", acc_cnt > a0, 1'b1);
    tick(); tick(); rst = 1'b1; s0 = strobe_cnt;
    tick(); rst = 1'b0;
    #4;
    chk("t6_req_dropped", ptw_req_valid, 1'b0);
    repeat (8) tick();
    #4;
    chk("t6_no_strobe", strobe_cnt, s0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_err_spurious", err_spurious, 1'b1);

    // Response arrives in the very cycle the timeout would fire: response wins.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; wk_lat = 8; req1_vpn = 27'h6000; req1_valid = 1'b1;
    wait_strobes(1, 40, "t7_done");
    chk("t7_latency", strobe_cyc - acc_cyc, 9);
    chk("t7_resp1_valid", resp1_valid, 1'b1);
    chk("t7_resp_ae", resp_ae, 1'b0);
    chk("t7_resp_pte", resp_pte, 64'h36005);
    chk("t7_err_timeout", err_timeout, 1'b0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
